sipo_reg_loader: RTL and testbench
==================================

Name: sipo_reg_loader

Overview:
- Serial-in/parallel-out front end that directly feeds the 16-bit load-enabled register bank (CLK, RESET, LOAD, reg_now[15:0]).
- Assembles WIDTH serial bits into a word, presents it on DATA_OUT (wired to reg_now), and pulses LOAD for exactly one cycle when the word is valid.
- Start/busy handshake, abort, and back-to-back frames supported.

Parameters:
- WIDTH, 16, word length in bits; legal range 2..64; counter width is $clog2(WIDTH).
- MSB_FIRST, 1, 1 = first received bit lands in DATA_OUT[WIDTH-1]; 0 = first received bit lands in DATA_OUT[0].

Ports:
- CLK  input  1  single system clock; all state changes on rising edge.
- RESET  input  1  synchronous, active-high reset; sampled on CLK rising edge; overrides all other inputs.
- START  input  1  frame request; honoured only in IDLE or DONE.
- SIN  input  1  serial data bit; sampled every cycle in SHIFT.
- ABORT  input  1  cancels a frame in progress; honoured only in SHIFT.
- BUSY  output  1  high while in SHIFT.
- LOAD  output  1  one-cycle pulse; DATA_OUT is valid in that cycle; drives the register's LOAD.
- DATA_OUT  output  WIDTH  last completed word; drives reg_now.
- BIT_CNT  output  $clog2(WIDTH)  bits received so far in the current frame.

Behaviour:
- Reset (RESET=1 at an edge):
  - state <= IDLE.
  - BUSY=0, LOAD=0, DATA_OUT=0, BIT_CNT=0, internal shift register = 0.
  - Applies in any state, including mid-frame; the partial word is discarded and no LOAD is issued.
- States: IDLE, SHIFT, DONE. All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.
- IDLE:
  - START=1 at an edge -> SHIFT, BIT_CNT<=0.
  - SIN is not sampled on the START edge.
- SHIFT:
  - Each edge samples SIN into the shift register and increments BIT_CNT.
  - Shift direction: MSB_FIRST=1 shifts left, new bit enters bit 0; MSB_FIRST=0 shifts right, new bit enters bit WIDTH-1.
  - Frame completion: on the edge where BIT_CNT==WIDTH-1:
    - DATA_OUT <= completed word (including the current SIN).
    - state <= DONE, BIT_CNT <= 0.
  - START during SHIFT is ignored.
  - ABORT=1 at any SHIFT edge -> IDLE, BIT_CNT<=0, DATA_OUT unchanged, no LOAD. ABORT beats completion on the final-bit edge.
- DONE (exactly one cycle):
  - LOAD=1 and BUSY=0; DATA_OUT holds the new word.
  - Next edge: START=1 -> SHIFT (back-to-back frame, zero idle cycles); otherwise -> IDLE.
- Latency and throughput:
  - START accepted at edge E0; bits sampled at E1..E_WIDTH; LOAD high in the cycle after E_WIDTH.
  - For WIDTH=16, LOAD is high 17 cycles after the START edge.
  - Back-to-back period: WIDTH+1 cycles per word.
- DATA_OUT:
  - Changes only on frame completion or reset.
  - Holds its value through IDLE, SHIFT and aborted frames, so the downstream register may be loaded at any later time without corruption.
- Priority at an edge: RESET > ABORT > frame completion > START.

Test Plan:
- Reset: hold RESET 2 cycles with START=1 and SIN toggling -> state IDLE, DATA_OUT=0x0000, LOAD=0, BUSY=0, BIT_CNT=0.
- Single frame, MSB_FIRST=1: pulse START, then shift 0xA5C3 MSB first -> BUSY high for 16 cycles; LOAD high exactly 1 cycle, 17 cycles after the START edge; DATA_OUT=0xA5C3; downstream register holds 0xA5C3.
- Back-to-back frames: assert START during DONE, shift 0x1234 then 0xFFFF -> LOAD pulses exactly 17 cycles apart; DATA_OUT=0x1234 then 0xFFFF; no idle cycle between frames.
- Ignored START and abort:
  - Pulse START at bit 5 -> no effect; BIT_CNT continues counting.
  - In a later frame, pulse ABORT at bit 15 (final-bit edge) -> IDLE, no LOAD, DATA_OUT keeps the previous word.
- Reset mid-frame: RESET at bit 8 of frame 0x00FF -> DATA_OUT=0x0000, no LOAD; a following frame 0x8001 completes correctly.
- MSB_FIRST=0, WIDTH=8: shift bits 1,0,0,0,0,0,0,0 -> DATA_OUT=0x01, LOAD pulse 9 cycles after the START edge.

Source files
------------

// File: rtl/sipo_reg_loader.sv
// sipo_reg_loader
//   Serial-in / parallel-out front end for a load-enabled register bank.
//   Collects WIDTH serial bits, publishes the finished word on DATA_OUT and
//   raises LOAD for exactly one cycle (the DONE state) while it is valid.
//
// Ports
//   CLK      in   system clock, rising edge
//   RESET    in   synchronous active-high reset, overrides everything
//   START    in   frame request, honoured in IDLE or DONE
//   SIN      in   serial bit, sampled every SHIFT cycle
//   ABORT    in   cancels a frame, honoured in SHIFT only
//   BUSY     out  high while shifting
//   LOAD     out  one-cycle strobe, DATA_OUT valid
//   DATA_OUT out  last completed word (held across idle/aborted frames)
//   BIT_CNT  out  bits received so far in the current frame
module sipo_reg_loader #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     START,
  input  logic                     SIN,
  input  logic                     ABORT,
  output logic                     BUSY,
  output logic                     LOAD,
  output logic [WIDTH-1:0]         DATA_OUT,
  output logic [$clog2(WIDTH)-1:0] BIT_CNT
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] shifted;
  logic             last_bit;

  // Direction is fixed at elaboration: left shift puts the first bit at the
  // MSB once the frame is full, right shift puts it at the LSB.
  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {shreg_q[WIDTH-2:0], SIN};
    end else begin : g_lsb
      assign shifted = {SIN, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        // ABORT wins even on the final-bit edge; DATA_OUT is left alone.
        if (ABORT) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          shreg_d = shifted;
          if (last_bit) begin
            data_d  = shifted;
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        // START here chains the next frame with no idle gap.
        state_d = START ? S_SHIFT : S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
    end
  end

  // Outputs are flops or pure state decodes: no input-to-output paths.
  assign BUSY     = (state_q == S_SHIFT);
  assign LOAD     = (state_q == S_DONE);
  assign DATA_OUT = data_q;
  assign BIT_CNT  = cnt_q;

endmodule

// File: tb/tb_sipo_reg_loader.sv
// tb_sipo_reg_loader
//   Drives two loaders (16-bit MSB-first, 8-bit LSB-first) through directed
//   and random frames. Expected words, held values, counts and latencies come
//   from the frame-level model in the tasks below.
module tb_sipo_reg_loader;

  logic        clk = 1'b0;
  logic        rst16 = 1'b0, start16 = 1'b0, sin16 = 1'b0, abort16 = 1'b0;
  logic        busy16, load16;
  logic [15:0] dout16;
  logic [3:0]  cnt16;
  logic        rst8 = 1'b0, start8 = 1'b0, sin8 = 1'b0, abort8 = 1'b0;
  logic        busy8, load8;
  logic [7:0]  dout8;
  logic [2:0]  cnt8;

  always #5 clk = ~clk;

  sipo_reg_loader #(.WIDTH(16), .MSB_FIRST(1'b1)) dut16 (
    .CLK(clk), .RESET(rst16), .START(start16), .SIN(sin16), .ABORT(abort16),
    .BUSY(busy16), .LOAD(load16), .DATA_OUT(dout16), .BIT_CNT(cnt16));

  sipo_reg_loader #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
    .CLK(clk), .RESET(rst8), .START(start8), .SIN(sin8), .ABORT(abort8),
    .BUSY(busy8), .LOAD(load8), .DATA_OUT(dout8), .BIT_CNT(cnt8));

  // Downstream register bank fed by the 16-bit loader.
  logic [15:0] reg_now = 16'h0;
  always @(posedge clk) if (load16) reg_now <= dout16;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nload16 = 0, nload8 = 0;
  always @(negedge clk) begin
    if (load16 === 1'b1) nload16 = nload16 + 1;
    if (load8  === 1'b1) nload8  = nload8 + 1;
  end

  int          vectors = 0, miscompares = 0;
  logic [63:0] held [2];
  logic [15:0] reg_exp = 16'h0;
  int          nexp [2];
  int          done_cyc [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input bit st, input bit si, input bit ab);
    if (sel == 0) begin start16 = st; sin16 = si; abort16 = ab; end
    else          begin start8  = st; sin8  = si; abort8  = ab; end
  endtask

  function automatic logic [63:0] f_busy(input int sel);
    return (sel == 0) ? 64'(busy16) : 64'(busy8);
  endfunction
  function automatic logic [63:0] f_load(input int sel);
    return (sel == 0) ? 64'(load16) : 64'(load8);
  endfunction
  function automatic logic [63:0] f_dout(input int sel);
    return (sel == 0) ? 64'(dout16) : 64'(dout8);
  endfunction
  function automatic logic [63:0] f_cnt(input int sel);
    return (sel == 0) ? 64'(cnt16) : 64'(cnt8);
  endfunction

  // One frame of word w. abort_at / glitch_at give the bit index at which
  // ABORT / START is asserted (-1 = never). Bit order follows the instance:
  // sel 0 sends w[15] first, sel 1 sends w[0] first.
  task automatic frame(input int sel, input logic [63:0] w, input int abort_at,
                       input int glitch_at);
    int W;
    int start_cyc;
    bit b2b;
    bit b;
    W = (sel == 0) ? 16 : 8;
    b2b = (done_cyc[sel] == cyc);
    start_cyc = cyc;
    drive(sel, 1'b1, 1'b0, 1'b0);
    tick();
    chk("start_busy", f_busy(sel), 1);
    chk("start_cnt", f_cnt(sel), 0);
    chk("start_load", f_load(sel), 0);
    for (int i = 0; i < W; i++) begin
      b = (sel == 0) ? w[W-1-i] : w[i];
      drive(sel, i == glitch_at, b, i == abort_at);
      tick();
      if (i == abort_at) begin
        chk("abort_busy", f_busy(sel), 0);
        chk("abort_load", f_load(sel), 0);
        chk("abort_cnt", f_cnt(sel), 0);
        chk("abort_dout", f_dout(sel), held[sel]);
        drive(sel, 1'b0, 1'b0, 1'b0);
        return;
      end
      if (i < W - 1) begin
        chk("shift_busy", f_busy(sel), 1);
        chk("shift_cnt", f_cnt(sel), 64'(i + 1));
        chk("shift_load", f_load(sel), 0);
        if (i == W / 2) chk("shift_dout_held", f_dout(sel), held[sel]);
      end else begin
        chk("done_load", f_load(sel), 1);
        chk("done_busy", f_busy(sel), 0);
        chk("done_cnt", f_cnt(sel), 0);
        chk("done_dout", f_dout(sel), w);
        chk("load_latency", 64'(cyc - start_cyc), 64'(W + 1));
        if (b2b) chk("b2b_period", 64'(cyc - done_cyc[sel]), 64'(W + 1));
        held[sel] = w;
        nexp[sel]++;
        done_cyc[sel] = cyc;
        if (sel == 0) reg_exp = w[15:0];
      end
    end
    drive(sel, 1'b0, 1'b0, 1'b0);
  endtask

  // A cycle with no START; ABORT and SIN are randomised since IDLE ignores them.
  task automatic idle_check(input int sel);
    drive(sel, 1'b0, 1'($urandom % 2), 1'($urandom % 2));
    tick();
    chk("idle_busy", f_busy(sel), 0);
    chk("idle_load", f_load(sel), 0);
    chk("idle_cnt", f_cnt(sel), 0);
    chk("idle_dout", f_dout(sel), held[sel]);
    if (sel == 0) chk("reg_now", 64'(reg_now), 64'(reg_exp));
    drive(sel, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] w16;
    logic [63:0] w;
    int sel, W, ab, gl, gap;
    held[0] = 0; held[1] = 0;
    nexp[0] = 0; nexp[1] = 0;
    done_cyc[0] = -1; done_cyc[1] = -1;

    // Reset held two cycles while START is high and SIN toggles.
    rst16 = 1'b1; rst8 = 1'b1; start16 = 1'b1; start8 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sin16 = 1'(i); sin8 = 1'(~i);
      tick();
    end
    for (int s = 0; s < 2; s++) begin
      chk("rst_busy", f_busy(s), 0);
      chk("rst_load", f_load(s), 0);
      chk("rst_cnt", f_cnt(s), 0);
      chk("rst_dout", f_dout(s), 0);
    end
    rst16 = 1'b0; rst8 = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    idle_check(0);
    idle_check(1);

    // Single frame, then back-to-back pair.
    frame(0, 64'hA5C3, -1, -1);
    idle_check(0);
    frame(0, 64'h1234, -1, -1);
    frame(0, 64'hFFFF, -1, -1);
    idle_check(0);

    // Ignored START at bit 5, then abort on the final-bit edge.
    w16 = 16'($urandom);
    frame(0, 64'(w16), -1, 5);
    idle_check(0);
    frame(0, 64'h5A5A, 15, -1);
    idle_check(0);

    // Reset in the middle of frame 0x00FF.
    w16 = 16'h00FF;
    drive(0, 1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'b0, w16[15-i], 1'b0);
      tick();
    end
    rst16 = 1'b1;
    drive(0, 1'b0, w16[7], 1'b0);
    tick();
    rst16 = 1'b0;
    held[0] = 0;
    chk("midrst_dout", 64'(dout16), 0);
    chk("midrst_load", 64'(load16), 0);
    chk("midrst_busy", 64'(busy16), 0);
    chk("midrst_cnt", 64'(cnt16), 0);
    idle_check(0);
    frame(0, 64'h8001, -1, -1);
    idle_check(0);

    // 8-bit LSB-first instance.
    frame(1, 64'h01, -1, -1);
    idle_check(1);

    // Random frames across both instances, random aborts/glitches/gaps.
    for (int k = 0; k < 30; k++) begin
      sel = int'($urandom % 2);
      W = (sel == 0) ? 16 : 8;
      w = {32'h0, $urandom} & ((64'h1 << W) - 1);
      ab = ($urandom % 4 == 0) ? int'($urandom % W) : -1;
      gl = ($urandom % 3 == 0) ? int'($urandom % W) : -1;
      frame(sel, w, ab, gl);
      gap = int'($urandom % 3);
      for (int g = 0; g < gap; g++) idle_check(sel);
    end

    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("load_count16", 64'(nload16), 64'(nexp[0]));
    chk("load_count8", 64'(nload8), 64'(nexp[1]));
    chk("final_reg_now", 64'(reg_now), 64'(reg_exp));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule
